// File: rtl/block_nest_pkg.sv
// Shared types and constants for the begin/end/case/endcase nesting checker.
package block_nest_pkg;

  typedef enum logic [2:0] {TOK_NONE, TOK_BEGIN, TOK_CASE, TOK_END, TOK_ENDCASE} tok_t;
  typedef enum logic {KIND_BEGIN, KIND_CASE} kind_t;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [63:0] KW_BEGIN    = {24'h0, "begin"};
  localparam logic [63:0] KW_CASE     = {32'h0, "case"};
  localparam logic [63:0] KW_END      = {40'h0, "end"};
  localparam logic [63:0] KW_ENDCASE  = {8'h0, "endcase"};
  localparam int unsigned NUM_KW      = 4;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

  function automatic logic [3:0] kw_len(input logic [1:0] k);
    case (k)
      2'd0:    return 4'd5;
      2'd1:    return 4'd4;
      2'd2:    return 4'd3;
      default: return 4'd7;
    endcase
  endfunction

  // Character p of keyword k; keyword strings are right-aligned, first char highest.
  function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [3:0] p);
    logic [63:0] s;
    logic [63:0] t;
    logic [5:0]  shamt;
    logic [3:0]  len;
    case (k)
      2'd0:    s = KW_BEGIN;
      2'd1:    s = KW_CASE;
      2'd2:    s = KW_END;
      default: s = KW_ENDCASE;
    endcase
    len   = kw_len(k);
    shamt = {3'(len - 4'd1 - p), 3'b000};
    t     = s >> shamt;
    return (p < len) ? t[7:0] : 8'h00;
  endfunction

  function automatic tok_t idx2tok(input logic [1:0] k);
    case (k)
      2'd0:    return TOK_BEGIN;
      2'd1:    return TOK_CASE;
      2'd2:    return TOK_END;
      default: return TOK_ENDCASE;
    endcase
  endfunction

endpackage

// File: rtl/nest_word_matcher.sv
// Space-delimited keyword matcher; emits a token combinationally on the terminating space.
module nest_word_matcher
  import block_nest_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  output tok_t       tok,
  output logic       tok_valid
);

  logic [3:0]        pos;
  logic [NUM_KW-1:0] alive;
  logic [NUM_KW-1:0] alive_nx;
  logic [7:0]        lc;
  logic              is_space;

  always_comb begin
    lc        = to_lower(in);
    is_space  = (in == ASCII_SPACE);
    tok_valid = in_valid && is_space;
    tok       = TOK_NONE;
    alive_nx  = '0;
    for (int unsigned k = 0; k < NUM_KW; k++) begin
      if (alive[k] && pos == kw_len(2'(k)))
        tok = idx2tok(2'(k));
      alive_nx[k] = alive[k] && (pos < kw_len(2'(k))) && (lc == kw_char(2'(k), pos));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos   <= '0;
      alive <= '1;
    end else if (in_valid) begin
      if (is_space) begin
        pos   <= '0;
        alive <= '1;
      end else begin
        pos   <= (pos == 4'd8) ? 4'd8 : pos + 4'd1;
        alive <= alive_nx;
      end
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Tracks begin/case nesting from a character stream; sticky error and overflow flags.
module block_nest_checker
  import block_nest_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic               overflow
);

  localparam int unsigned        IDX_W = $clog2(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  tok_t  tok;
  logic  tok_valid;
  kind_t stack [MAX_DEPTH];
  kind_t tok_kind;
  kind_t top_kind;
  logic  is_opener;
  logic  is_closer;
  logic  push;
  logic  error_nx;
  logic  overflow_nx;
  logic [DEPTH_W-1:0] depth_nx;
  logic [IDX_W-1:0]   top_idx;

  nest_word_matcher u_matcher (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .tok       (tok),
    .tok_valid (tok_valid)
  );

  always_comb begin
    is_opener   = (tok == TOK_BEGIN) || (tok == TOK_CASE);
    is_closer   = (tok == TOK_END) || (tok == TOK_ENDCASE);
    tok_kind    = ((tok == TOK_CASE) || (tok == TOK_ENDCASE)) ? KIND_CASE : KIND_BEGIN;
    top_idx     = (depth == '0) ? '0 : IDX_W'(depth - 1'b1);
    top_kind    = stack[top_idx];
    push        = 1'b0;
    depth_nx    = depth;
    error_nx    = error;
    overflow_nx = overflow;
    if (tok_valid && is_opener) begin
      if (depth == MAX_D) begin
        error_nx    = 1'b1;
        overflow_nx = 1'b1;
      end else begin
        push     = 1'b1;
        depth_nx = depth + 1'b1;
      end
    end else if (tok_valid && is_closer) begin
      if (depth == '0) begin
        error_nx = 1'b1;
      end else begin
        // A mismatched closer still pops so later words resynchronise.
        if (top_kind != tok_kind)
          error_nx = 1'b1;
        depth_nx = depth - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth    <= '0;
      error    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      depth    <= depth_nx;
      error    <= error_nx;
      overflow <= overflow_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      stack[IDX_W'(depth)] <= tok_kind;
  end

  assign result = (depth == '0) && !error;

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed bench: word-level reference model for two checker instances (depth 16 and 4).
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_c;
  logic       in_valid;

  logic       r16, e16, o16;
  logic [4:0] d16;
  logic       r4, e4, o4;
  logic [2:0] d4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  block_nest_checker dut16 (
    .clk(clk), .reset(reset), .in(in_c), .in_valid(in_valid),
    .result(r16), .depth(d16), .error(e16), .overflow(o16)
  );

  block_nest_checker #(.MAX_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .in(in_c), .in_valid(in_valid),
    .result(r4), .depth(d4), .error(e4), .overflow(o4)
  );

  // Reference model: accumulate a word, classify it by string comparison at the space.
  byte m_word[$];
  int  m_d[2];
  bit  m_e[2];
  bit  m_o[2];
  int  m_stk[2][16];
  int  maxd[2] = '{16, 4};

  function automatic byte lower(input byte c);
    return (c >= "A" && c <= "Z") ? byte'(c + 8'd32) : c;
  endfunction

  function automatic bit word_is(input string kw);
    if (m_word.size() != kw.len()) return 1'b0;
    for (int i = 0; i < kw.len(); i++)
      if (lower(m_word[i]) != kw[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_word.delete();
    for (int i = 0; i < 2; i++) begin
      m_d[i] = 0; m_e[i] = 0; m_o[i] = 0;
    end
  endfunction

  function automatic void model_word();
    int op, kind;
    op = 0; kind = 0;
    if (word_is("begin"))        begin op = 1; kind = 0; end
    else if (word_is("case"))    begin op = 1; kind = 1; end
    else if (word_is("end"))     begin op = 2; kind = 0; end
    else if (word_is("endcase")) begin op = 2; kind = 1; end
    for (int i = 0; i < 2; i++) begin
      if (op == 1) begin
        if (m_d[i] == maxd[i]) begin m_e[i] = 1; m_o[i] = 1; end
        else begin m_stk[i][m_d[i]] = kind; m_d[i]++; end
      end else if (op == 2) begin
        if (m_d[i] == 0) m_e[i] = 1;
        else begin
          if (m_stk[i][m_d[i]-1] != kind) m_e[i] = 1;
          m_d[i]--;
        end
      end
    end
  endfunction

  function automatic void model_step(input byte c, input bit v);
    if (!v) return;
    if (c == " ") begin
      model_word();
      m_word.delete();
    end else begin
      m_word.push_back(c);
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("depth16",  int'(d16), m_d[0]);
    chk("error16",  int'(e16), int'(m_e[0]));
    chk("ovf16",    int'(o16), int'(m_o[0]));
    chk("result16", int'(r16), int'(m_d[0] == 0 && !m_e[0]));
    chk("depth4",   int'(d4),  m_d[1]);
    chk("error4",   int'(e4),  int'(m_e[1]));
    chk("ovf4",     int'(o4),  int'(m_o[1]));
    chk("result4",  int'(r4),  int'(m_d[1] == 0 && !m_e[1]));
  endtask

  // Every cycle passes through here: check outputs, then drive the next input.
  task automatic put(input byte c, input bit v);
    @(negedge clk);
    compare_all();
    in_c     = c;
    in_valid = v;
    model_step(c, v);
  endtask

  task automatic send(input string s, input bit toggle);
    for (int i = 0; i < s.len(); i++) begin
      put(s[i], 1'b1);
      if (toggle) put(8'h20, 1'b0);
    end
    put(8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_all();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_depth16",  int'(d16), 0);
    chk("rst_result16", int'(r16), 1);
    chk("rst_error16",  int'(e16), 0);
    chk("rst_depth4",   int'(d4),  0);
    @(negedge clk);
    compare_all();
    #2 reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    in_c     = 8'h00;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("init_depth16",  int'(d16), 0);
    chk("init_result16", int'(r16), 1);
    chk("init_ovf16",    int'(o16), 0);
    #20 reset = 1'b1;

    // Mixed-case balanced nesting
    send("BEGIN ", 1'b0);   chk("s1_d_a", int'(d16), 1);
    send("case ", 1'b0);    chk("s1_d_b", int'(d16), 2);
    send("EndCase ", 1'b0); chk("s1_d_c", int'(d16), 1);
    send("end ", 1'b0);     chk("s1_d_d", int'(d16), 0);
    chk("s1_result", int'(r16), 1);
    chk("s1_error",  int'(e16), 0);

    // Mismatched closer is sticky
    do_reset();
    send("begin endcase ", 1'b0);
    chk("s2_error", int'(e16), 1);
    chk("s2_depth", int'(d16), 0);
    chk("s2_result", int'(r16), 0);
    send("begin end ", 1'b0);
    chk("s2_result_after", int'(r16), 0);

    // Closer at depth 0
    do_reset();
    send("end ", 1'b0);
    chk("s3_error_first", int'(e16), 1);
    chk("s3_depth_first", int'(d16), 0);
    send("begin end ", 1'b0);
    chk("s3_depth", int'(d16), 0);
    chk("s3_result", int'(r16), 0);

    // Overflow on the depth-4 instance
    do_reset();
    for (int i = 0; i < 5; i++) send("begin ", 1'b0);
    chk("s4_depth4", int'(d4), 4);
    chk("s4_ovf4",   int'(o4), 1);
    chk("s4_err4",   int'(e4), 1);
    chk("s4_depth16", int'(d16), 5);
    chk("s4_ovf16",  int'(o16), 0);
    for (int i = 0; i < 4; i++) send("end ", 1'b0);
    chk("s4_depth4_end", int'(d4), 0);
    chk("s4_result4",    int'(r4), 0);
    chk("s4_depth16_end", int'(d16), 1);

    // Non-keywords with gaps in in_valid (idle cycles carry a space)
    do_reset();
    send("beginx ends begi ", 1'b1);
    chk("s5_depth",  int'(d16), 0);
    chk("s5_result", int'(r16), 1);
    send("  begin  ", 1'b1);
    chk("s5_depth_b", int'(d16), 1);

    // Reset mid-word discards the partial word and open blocks
    do_reset();
    send("begin case en", 1'b0);
    chk("s6_depth_pre", int'(d16), 2);
    do_reset();
    chk("s6_depth_post",  int'(d16), 0);
    chk("s6_result_post", int'(r16), 1);
    send("end ", 1'b0);
    chk("s6_error", int'(e16), 1);

    put(8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
